input_frame_scheduler: RTL and testbench
========================================

Name: input_frame_scheduler

Overview:
- Frame-granular round-robin arbiter that shares the ConvNet accelerator input layer between two pixel sources.
- Each source streams whole frames of INPUT_SPATIAL_DIM pixels. The scheduler grants one source for exactly one frame, then re-arbitrates.
- After FRAME_SIZE frames it stops and flags done.
- Sits between the stimulus/host sources and the accelerator input_layer_valid/rdy/data port.

Parameters:
- Nin, 3, input feature map number (channels per pixel word)
- BIT_WIDTH, 8, bit width of each channel
- INPUT_SPATIAL_DIM, 25, pixels per frame (>=1)
- FRAME_SIZE, 4, total frames to schedule per run (>=1)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a run (honoured in IDLE and DONE only)
- src0_valid  input  1  source 0 pixel valid
- src0_data  input  Nin*BIT_WIDTH  source 0 pixel, channel ii at [ii*BIT_WIDTH+:BIT_WIDTH]
- src0_rdy  output  1  source 0 ready
- src1_valid  input  1  source 1 pixel valid
- src1_data  input  Nin*BIT_WIDTH  source 1 pixel
- src1_rdy  output  1  source 1 ready
- input_layer_rdy  input  1  accelerator input ready
- input_layer_valid  output  1  accelerator input valid
- input_layer_data  output  Nin*BIT_WIDTH  accelerator input data
- cur_src  output  1  index of granted source (meaningful in STREAM)
- frame_start  output  1  pulse: first pixel of a frame accepted this cycle
- frame_end  output  1  pulse: last pixel of a frame accepted this cycle
- frame_cnt  output  clog2(FRAME_SIZE+1)  frames completed this run
- done  output  1  high in DONE

Behaviour:
- Clock and reset: one clock domain. rst is sampled at posedge clk only.
- Reset values: state=IDLE, rr_ptr=0, cur_src=0, pixel_cnt=0, frame_cnt=0, done=0. All rdy/valid outputs, frame_start and frame_end are 0.
- Reset mid-operation: abandons any partial frame immediately with no drain. Outputs return to reset values the next cycle.
- States: IDLE, ARB, STREAM, DONE.
- IDLE:
  - All handshakes deasserted.
  - start -> ARB; pixel_cnt and frame_cnt cleared.
- ARB:
  - Handshakes deasserted; costs exactly one cycle when a request exists.
  - Priority goes to source rr_ptr. If its valid is low and the other source's valid is high, grant the other.
  - Grant latches cur_src and moves to STREAM.
  - Neither valid -> stay in ARB.
- STREAM: zero-latency combinational pass-through from the granted source.
  - input_layer_valid = srcX_valid[cur_src].
  - input_layer_data = srcX_data[cur_src].
  - srcX_rdy[cur_src] = input_layer_rdy.
  - The non-granted rdy is 0.
  - When cur_src=0, input_layer_data equals src0_data.
- Handshake definition: a pixel transfers when input_layer_valid && input_layer_rdy in the same cycle. On each transfer pixel_cnt increments.
- frame_start: combinational, asserted on the transfer where pixel_cnt==0.
- frame_end: combinational, asserted on the transfer where pixel_cnt==INPUT_SPATIAL_DIM-1. On that transfer:
  - pixel_cnt <- 0
  - frame_cnt <- frame_cnt+1
  - rr_ptr <- ~cur_src
  - next state is DONE if frame_cnt==FRAME_SIZE-1, else ARB
- INPUT_SPATIAL_DIM=1: frame_start and frame_end assert on the same transfer.
- Frame lock: the grant never changes mid-frame, regardless of the other source's valid. A stalled granted source (valid low) holds STREAM indefinitely.
- Upstream behaviour: valid may drop between pixels; the scheduler tolerates it.
- DONE:
  - done=1; handshakes deasserted; frame_cnt holds FRAME_SIZE.
  - start -> ARB with counters cleared and done cleared; rr_ptr retained.
- start outside IDLE/DONE: ignored.
- Counter widths: pixel_cnt is clog2(INPUT_SPATIAL_DIM) bits, with a minimum of 1. No counter wraps within a run.

Test Plan:
- Reset, start, only src0 valid, data 1,2,3… with input_layer_rdy=1 -> one ARB cycle, then 25 transfers.
  - frame_start on pixel 1, frame_end on pixel 25.
  - Repeats for 4 frames, all from src0 (src1 idle).
  - Ends with frame_cnt=4, done=1, src0_rdy=0.
- Both sources valid continuously -> frames are granted src0, src1, src0, src1.
  - Each frame is exactly 25 transfers.
  - The non-granted rdy stays 0 throughout.
- Accelerator backpressure (input_layer_rdy toggling 1,0,1,0) -> data held stable while rdy=0.
  - No pixel lost or duplicated; pixel_cnt advances only on handshakes.
- src1 asserts valid at pixel 10 of a src0 frame -> no grant change until src0 pixel 25 is accepted.
  - The next frame goes to src1.
- rst asserted at pixel 12 of frame 2 -> next cycle state=IDLE, counters 0, all rdy/valid 0.
  - A subsequent start runs a full 4 frames.
- INPUT_SPATIAL_DIM=1, FRAME_SIZE=1 -> a single transfer asserts frame_start and frame_end together.
  - done is high the following cycle.

Source files
------------

// File: rtl/input_frame_scheduler.sv
// Frame-granular round-robin arbiter sharing the accelerator input layer between two pixel sources.
// A source keeps the grant for one whole frame; after FRAME_SIZE frames the run stops in DONE.
module input_frame_scheduler #(
  parameter int Nin               = 3,
  parameter int BIT_WIDTH         = 8,
  parameter int INPUT_SPATIAL_DIM = 25,
  parameter int FRAME_SIZE        = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                src0_valid,
  input  logic [Nin*BIT_WIDTH-1:0]            src0_data,
  output logic                                src0_rdy,
  input  logic                                src1_valid,
  input  logic [Nin*BIT_WIDTH-1:0]            src1_data,
  output logic                                src1_rdy,
  input  logic                                input_layer_rdy,
  output logic                                input_layer_valid,
  output logic [Nin*BIT_WIDTH-1:0]            input_layer_data,
  output logic                                cur_src,
  output logic                                frame_start,
  output logic                                frame_end,
  output logic [$clog2(FRAME_SIZE+1)-1:0]     frame_cnt,
  output logic                                done,
  output logic [1:0]                          state_dbg
);

  localparam int PW = (INPUT_SPATIAL_DIM > 1) ? $clog2(INPUT_SPATIAL_DIM) : 1;
  localparam int FW = $clog2(FRAME_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            rr_ptr;
  logic [PW-1:0]   pixel_cnt;
  logic            sel_valid;
  logic            xfer;
  logic            last_pix;
  logic            last_frame;
  logic            clear;
  logic            grant;
  logic            grant_ok;

  assign last_pix   = (pixel_cnt == PW'(INPUT_SPATIAL_DIM - 1));
  assign last_frame = (frame_cnt == FW'(FRAME_SIZE - 1));
  assign done       = (state_q == DONE);
  assign state_dbg  = state_q;

  // Handshake: a pixel moves when valid && rdy are both high in the same cycle; the
  // granted source sees the accelerator's rdy directly and valid may drop between pixels.
  always_comb begin
    state_d           = state_q;
    input_layer_valid = 1'b0;
    src0_rdy          = 1'b0;
    src1_rdy          = 1'b0;
    xfer              = 1'b0;
    frame_start       = 1'b0;
    frame_end         = 1'b0;
    clear             = 1'b0;
    grant             = rr_ptr;
    grant_ok          = 1'b0;
    sel_valid         = cur_src ? src1_valid : src0_valid;
    input_layer_data  = cur_src ? src1_data : src0_data;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARB;
          clear   = 1'b1;
        end
      end
      ARB: begin
        if (rr_ptr ? src1_valid : src0_valid) begin
          grant    = rr_ptr;
          grant_ok = 1'b1;
        end else if (rr_ptr ? src0_valid : src1_valid) begin
          grant    = ~rr_ptr;
          grant_ok = 1'b1;
        end
        if (grant_ok) state_d = STREAM;
      end
      STREAM: begin
        // Grant is frozen for the whole frame; only the frame's last transfer leaves STREAM.
        input_layer_valid = sel_valid;
        src0_rdy          = ~cur_src & input_layer_rdy;
        src1_rdy          = cur_src & input_layer_rdy;
        xfer              = sel_valid & input_layer_rdy;
        frame_start       = xfer & (pixel_cnt == '0);
        frame_end         = xfer & last_pix;
        if (frame_end) state_d = last_frame ? DONE : ARB;
      end
      DONE: begin
        if (start) begin
          state_d = ARB;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr    <= 1'b0;
      cur_src   <= 1'b0;
      pixel_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        pixel_cnt <= '0;
        frame_cnt <= '0;
      end
      if (grant_ok) cur_src <= grant;
      if (xfer) begin
        if (last_pix) begin
          pixel_cnt <= '0;
          frame_cnt <= frame_cnt + 1'b1;
          rr_ptr    <= ~cur_src;
        end else begin
          pixel_cnt <= pixel_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_input_frame_scheduler.sv
// Directed bench for input_frame_scheduler: round-robin grant, frame lock, backpressure,
// mid-run reset and a single-pixel/single-frame instance.
module tb_input_frame_scheduler;

  localparam int NIN = 3;
  localparam int BW  = 8;
  localparam int DW  = NIN * BW;
  localparam int ISD = 25;
  localparam int FS  = 4;
  localparam int FW  = $clog2(FS + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance (25 pixels, 4 frames)
  logic          start = 1'b0;
  logic          src0_valid = 1'b0, src1_valid = 1'b0, input_layer_rdy = 1'b0;
  logic [DW-1:0] src0_data = '0, src1_data = '0;
  logic          src0_rdy, src1_rdy, input_layer_valid, cur_src, frame_start, frame_end, done;
  logic [DW-1:0] input_layer_data;
  logic [FW-1:0] frame_cnt;
  logic [1:0]    state_dbg;

  input_frame_scheduler #(.Nin(NIN), .BIT_WIDTH(BW), .INPUT_SPATIAL_DIM(ISD), .FRAME_SIZE(FS)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .src0_valid(src0_valid), .src0_data(src0_data), .src0_rdy(src0_rdy),
    .src1_valid(src1_valid), .src1_data(src1_data), .src1_rdy(src1_rdy),
    .input_layer_rdy(input_layer_rdy), .input_layer_valid(input_layer_valid),
    .input_layer_data(input_layer_data), .cur_src(cur_src), .frame_start(frame_start),
    .frame_end(frame_end), .frame_cnt(frame_cnt), .done(done), .state_dbg(state_dbg)
  );

  // single-pixel, single-frame instance
  logic          b_start = 1'b0, b_s0v = 1'b0, b_s1v = 1'b0, b_rdy = 1'b0;
  logic [DW-1:0] b_s0d = '0, b_s1d = '0;
  logic          b_s0_rdy, b_s1_rdy, b_valid, b_cur, b_fs, b_fe, b_done;
  logic [DW-1:0] b_data;
  logic [0:0]    b_fcnt;
  logic [1:0]    b_state;

  input_frame_scheduler #(.Nin(NIN), .BIT_WIDTH(BW), .INPUT_SPATIAL_DIM(1), .FRAME_SIZE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(b_start),
    .src0_valid(b_s0v), .src0_data(b_s0d), .src0_rdy(b_s0_rdy),
    .src1_valid(b_s1v), .src1_data(b_s1d), .src1_rdy(b_s1_rdy),
    .input_layer_rdy(b_rdy), .input_layer_valid(b_valid),
    .input_layer_data(b_data), .cur_src(b_cur), .frame_start(b_fs),
    .frame_end(b_fe), .frame_cnt(b_fcnt), .done(b_done), .state_dbg(b_state)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int s_idx[2];   // source models: next pixel index each source presents
  int e_idx[2];   // expectation: next pixel index the bench expects from each source
  int total  = 0;
  int passed = 0;

  function automatic logic [DW-1:0] mk(input logic s, input int i);
    return {(s ? 8'hB1 : 8'hA0), i[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock; a source advances to its next pixel only after a handshake it saw.
  task automatic step();
    logic h0, h1;
    h0 = src0_valid && src0_rdy;
    h1 = src1_valid && src1_rdy;
    @(posedge clk);
    #1;
    if (h0 === 1'b1) s_idx[0]++;
    if (h1 === 1'b1) s_idx[1]++;
    src0_data = mk(1'b0, s_idx[0]);
    src1_data = mk(1'b1, s_idx[1]);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
  endtask

  // Streams nfr frames; srcs[f] is the source expected to own frame f. stop_after>0 cuts
  // the last frame short after that many transfers.
  task automatic stream_frames(input int nfr, input logic [3:0] srcs, input bit toggle,
                               input bit inject, input int stop_after);
    for (int f = 0; f < nfr; f++) begin
      logic xs;
      int   pix, budget, lim;
      xs = srcs[f];
      total++;
      if (input_layer_valid !== 1'b0 || src0_rdy !== 1'b0 || src1_rdy !== 1'b0 || state_dbg !== 2'd1)
        $display("FAIL arb_cycle f=%0d: valid=%b rdy0=%b rdy1=%b state=%0d, need 0 0 0 1",
                 f, input_layer_valid, src0_rdy, src1_rdy, state_dbg);
      else passed++;
      step();
      for (int k = 0; k < ISD; k++) begin
        exp_q.push_back(mk(xs, e_idx[xs]));
        e_idx[xs]++;
      end
      pix    = 0;
      budget = 0;
      lim    = (stop_after > 0 && f == nfr - 1) ? stop_after : ISD;
      while (pix < lim && budget < 4 * ISD + 10) begin
        if (inject && f == 0 && pix == 9) begin
          src1_valid = 1'b1;
          #1;
        end
        if (toggle) begin
          input_layer_rdy = (budget % 2 == 0);
          #1;
        end
        total++;
        if (cur_src !== xs || (xs ? src0_rdy : src1_rdy) !== 1'b0 ||
            (xs ? src1_rdy : src0_rdy) !== input_layer_rdy)
          $display("FAIL grant f=%0d pix=%0d: cur_src=%b rdy0=%b rdy1=%b, need cur_src=%b rdy_granted=%b other=0",
                   f, pix, cur_src, src0_rdy, src1_rdy, xs, input_layer_rdy);
        else passed++;
        if (input_layer_valid === 1'b1 && input_layer_rdy === 1'b1) begin
          logic [DW-1:0] exp_d;
          exp_d = exp_q.pop_front();
          total++;
          if (input_layer_data !== exp_d || frame_start !== (pix == 0) || frame_end !== (pix == ISD - 1))
            $display("FAIL xfer f=%0d pix=%0d: data=%h fs=%b fe=%b, need data=%h fs=%b fe=%b",
                     f, pix, input_layer_data, frame_start, frame_end, exp_d, pix == 0, pix == ISD - 1);
          else passed++;
          pix++;
        end else if (input_layer_valid === 1'b1) begin
          total++;
          if (input_layer_data !== exp_q[0] || frame_start !== 1'b0 || frame_end !== 1'b0)
            $display("FAIL hold f=%0d pix=%0d: data=%h fs=%b fe=%b, need data=%h fs=0 fe=0",
                     f, pix, input_layer_data, frame_start, frame_end, exp_q[0]);
          else passed++;
        end
        step();
        budget++;
      end
      if (pix < lim) begin
        total++;
        $display("FAIL frame_timeout f=%0d: got %0d transfers, need %0d", f, pix, lim);
      end
      if (lim == ISD) begin
        total++;
        if (frame_cnt !== FW'(f + 1))
          $display("FAIL frame_cnt f=%0d: got %0d, need %0d", f, frame_cnt, f + 1);
        else passed++;
      end else begin
        e_idx[xs] -= exp_q.size();
        exp_q.delete();
      end
    end
  endtask

  task automatic check_done(input string tag);
    total++;
    if (done !== 1'b1 || frame_cnt !== FW'(FS) || state_dbg !== 2'd3 ||
        input_layer_valid !== 1'b0 || src0_rdy !== 1'b0 || src1_rdy !== 1'b0)
      $display("FAIL %s_done: done=%b frame_cnt=%0d state=%0d valid=%b rdy0=%b rdy1=%b, need 1 %0d 3 0 0 0",
               tag, done, frame_cnt, state_dbg, input_layer_valid, src0_rdy, src1_rdy, FS);
    else passed++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if ({state_dbg, done, frame_cnt, input_layer_valid, src0_rdy, src1_rdy, frame_start, frame_end, cur_src} !== '0)
      $display("FAIL reset_main: state=%0d done=%b fcnt=%0d valid=%b rdy0=%b rdy1=%b fs=%b fe=%b cur=%b, need all 0",
               state_dbg, done, frame_cnt, input_layer_valid, src0_rdy, src1_rdy, frame_start, frame_end, cur_src);
    else passed++;
    total++;
    if ({b_state, b_done, b_fcnt, b_valid, b_s0_rdy, b_s1_rdy} !== '0)
      $display("FAIL reset_single: state=%0d done=%b fcnt=%0d valid=%b, need all 0", b_state, b_done, b_fcnt, b_valid);
    else passed++;
    rst = 1'b0;
    step();
    total++;
    if (state_dbg !== 2'd0 || src0_rdy !== 1'b0)
      $display("FAIL idle_hold: state=%0d rdy0=%b, need 0 0", state_dbg, src0_rdy);
    else passed++;
  endtask

  task automatic test_single_source();
    src0_valid = 1'b1;
    src1_valid = 1'b0;
    input_layer_rdy = 1'b1;
    pulse_start();
    stream_frames(4, 4'b0000, 1'b0, 1'b0, 0);
    check_done("single");
    step();
    check_done("single_hold");
  endtask

  task automatic test_round_robin();
    src0_valid = 1'b1;
    src1_valid = 1'b1;
    pulse_start();
    total++;
    if (done !== 1'b0 || frame_cnt !== '0)
      $display("FAIL restart_clear: done=%b frame_cnt=%0d, need 0 0", done, frame_cnt);
    else passed++;
    // pointer kept from the previous run (last frame was src0), so src1 goes first
    stream_frames(4, 4'b0101, 1'b0, 1'b0, 0);
    check_done("rr");
  endtask

  task automatic test_backpressure();
    src0_valid = 1'b1;
    src1_valid = 1'b0;
    pulse_start();
    stream_frames(4, 4'b0000, 1'b1, 1'b0, 0);
    check_done("bp");
    input_layer_rdy = 1'b1;
    #1;
  endtask

  task automatic test_frame_lock();
    rst = 1'b1;
    step();
    rst = 1'b0;
    src0_valid = 1'b1;
    src1_valid = 1'b0;
    #1;
    pulse_start();
    stream_frames(4, 4'b1010, 1'b0, 1'b1, 0);
    check_done("lock");
  endtask

  task automatic test_reset_mid();
    src0_valid = 1'b1;
    src1_valid = 1'b1;
    pulse_start();
    stream_frames(2, 4'b0010, 1'b0, 1'b0, 12);
    input_layer_rdy = 1'b0;
    #1;
    rst = 1'b1;
    step();
    total++;
    if (state_dbg !== 2'd0 || frame_cnt !== '0 || done !== 1'b0 || input_layer_valid !== 1'b0 ||
        src0_rdy !== 1'b0 || src1_rdy !== 1'b0)
      $display("FAIL mid_reset: state=%0d fcnt=%0d done=%b valid=%b rdy0=%b rdy1=%b, need all 0",
               state_dbg, frame_cnt, done, input_layer_valid, src0_rdy, src1_rdy);
    else passed++;
    rst = 1'b0;
    input_layer_rdy = 1'b1;
    #1;
    pulse_start();
    stream_frames(4, 4'b1010, 1'b0, 1'b0, 0);
    check_done("after_reset");
  endtask

  task automatic test_single_pixel();
    b_s0v = 1'b1;
    b_s0d = 24'h5A3C96;
    b_rdy = 1'b1;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    #1;
    total++;
    if (b_state !== 2'd1 || b_valid !== 1'b0 || b_s0_rdy !== 1'b0)
      $display("FAIL sp_arb: state=%0d valid=%b rdy0=%b, need 1 0 0", b_state, b_valid, b_s0_rdy);
    else passed++;
    step();
    total++;
    if (b_valid !== 1'b1 || b_data !== 24'h5A3C96 || b_fs !== 1'b1 || b_fe !== 1'b1 || b_s0_rdy !== 1'b1)
      $display("FAIL sp_xfer: valid=%b data=%h fs=%b fe=%b rdy0=%b, need 1 5a3c96 1 1 1",
               b_valid, b_data, b_fs, b_fe, b_s0_rdy);
    else passed++;
    step();
    total++;
    if (b_done !== 1'b1 || b_fcnt !== 1'b1 || b_valid !== 1'b0 || b_s0_rdy !== 1'b0)
      $display("FAIL sp_done: done=%b fcnt=%0d valid=%b rdy0=%b, need 1 1 0 0", b_done, b_fcnt, b_valid, b_s0_rdy);
    else passed++;
    b_s0v = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    s_idx[0] = 0; s_idx[1] = 0;
    e_idx[0] = 0; e_idx[1] = 0;
    src0_data = mk(1'b0, 0);
    src1_data = mk(1'b1, 0);
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_frame_lock();
    test_reset_mid();
    test_single_pixel();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
